bus_fifo_mailbox: RTL and testbench
===================================

BUS_FIFO_MAILBOX -- requirements
Module: bus_fifo_mailbox

Interface
REQ-001 SHALL have parameter Depth, default 16, FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter DataWidth, default 32, bus data width; only 32 is supported.
REQ-003 SHALL have parameter AddressWidth, default 32, bus address width.
REQ-004 SHALL have port CLK, input, 1, system clock; all state updates on the rising edge.
REQ-005 SHALL have port RST_N, input, 1, reset: asynchronous assert, active-low.
REQ-006 SHALL have port device_req_i, input, 1, bus request; no grant is returned, every req is accepted.
REQ-007 SHALL have port device_addr_i, input, AddressWidth, byte address; only bits [3:2] are decoded.
REQ-008 SHALL have port device_we_i, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port device_be_i, input, 4, byte enables.
REQ-010 SHALL have port device_wdata_i, input, DataWidth, write data.
REQ-011 SHALL have port device_rvalid_o, output, 1, response valid.
REQ-012 SHALL have port device_rdata_o, output, DataWidth, read data.
REQ-013 SHALL have port device_err_o, output, 1, error flag, qualified by rvalid.
REQ-014 SHALL have port irq_o, output, 1, level interrupt.

Function
REQ-015 SHALL decode the register map by addr[3:2]: 0 = DATA, 1 = STATUS, 2 = CTRL, 3 = THRESH; addr[AddressWidth-1:4] are ignored (aliasing).
REQ-016 SHALL assert device_rvalid_o for exactly one cycle, the cycle after each req (read or write); back-to-back reqs give back-to-back rvalids.
REQ-017 SHALL register device_rdata_o and device_err_o, presented with rvalid; rdata SHALL be 0 for writes and for error responses.
REQ-018 SHALL handle a DATA write as follows: with be == 4'hF and not full, push wdata at wr_ptr, wr_ptr++, count++.
REQ-019 SHALL handle a DATA write when full or when be != 4'hF as follows: no push, err = 1; if full, set sticky overflow.
REQ-020 SHALL handle a DATA read as follows: when not empty, return the head entry, rd_ptr++, count--; when empty, err = 1, rdata = 0, set sticky underflow, no pointer change.
REQ-021 SHALL implement pointers of width clog2(Depth) that wrap modulo Depth; count SHALL be clog2(Depth)+1 bits with range 0..Depth.
REQ-022 SHALL define STATUS (read-only) as: bit0 empty, bit1 full, bit2 overflow, bit3 underflow, bits[15:8] count (zero-extended), all other bits 0; a STATUS write SHALL be ignored with no error.
REQ-023 SHALL define CTRL as: bit0 irq_en (read/write, lane 0 only when be[0]); bit1 clear (write-1, self-clearing, reads 0).
REQ-024 SHALL have a clear write reset the pointers and count to 0 and clear overflow/underflow, effective from the next cycle; FIFO contents need not be erased.
REQ-025 SHALL define THRESH bits[clog2(Depth):0] as read/write via lane 0; a written value above Depth SHALL saturate to Depth, and 0 SHALL store as 1.
REQ-026 SHALL drive irq_o = irq_en AND (count >= THRESH), decoded from registers only (glitch-free) and deasserting in the cycle after count drops below THRESH.
REQ-027 SHALL apply CTRL.clear and irq_en together when a single CTRL write sets both; irq_o then evaluates against count = 0.
REQ-028 SHALL treat reads with be != 4'hF to any register as full-word reads; only DATA writes check be.

Reset
REQ-029 SHALL, while RST_N = 0, immediately drive device_rvalid_o, device_err_o and irq_o to 0 and device_rdata_o to 0.
REQ-030 SHALL reset pointers, count, overflow, underflow and irq_en to 0 and THRESH to 1.
REQ-031 SHALL discard any response pending when reset asserts mid-operation; the first req after RST_N deassertion SHALL be served normally.

Verification
REQ-032 SHALL verify push/pop ordering: write 0x11, 0x22, 0x33 to DATA, then read DATA three times -> rdata 0x11, 0x22, 0x33 each one cycle after req, err = 0, STATUS.count = 0, empty = 1.
REQ-033 SHALL verify full and wrap: push 17 words (Depth 16) -> 17th has err = 1, STATUS = full | overflow with count = 16; pop 16, push 0xAA, pop -> 0xAA (pointer wrap).
REQ-034 SHALL verify the empty-read error: read DATA after reset -> rvalid = 1, err = 1, rdata = 0, STATUS bit3 = 1; write CTRL = 0x2 -> STATUS reads 0x1.
REQ-035 SHALL verify the interrupt threshold: THRESH = 3, irq_en = 1; push 2 -> irq_o = 0; push 3rd -> irq_o = 1; pop 1 -> irq_o = 0; write THRESH = 0 -> reads back 1.
REQ-036 SHALL verify the byte-enable check: DATA write with be = 4'h3 -> err = 1, count unchanged; back-to-back req on every cycle -> one rvalid per cycle with no loss.
REQ-037 SHALL verify reset mid-operation: assert RST_N low in the cycle after a read req -> no rvalid; after release, STATUS = 0x1 and THRESH = 1.

Source files
------------

// File: rtl/bus_fifo_mailbox.sv
// Bus-attached FIFO mailbox: DATA push/pop port plus STATUS, CTRL and THRESH registers.
// Single-cycle registered response for every request; level interrupt on fill threshold.
module bus_fifo_mailbox #(
    parameter int Depth        = 16,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    device_req_i,
    input  logic [AddressWidth-1:0] device_addr_i,
    input  logic                    device_we_i,
    input  logic [3:0]              device_be_i,
    input  logic [DataWidth-1:0]    device_wdata_i,
    output logic                    device_rvalid_o,
    output logic [DataWidth-1:0]    device_rdata_o,
    output logic                    device_err_o,
    output logic                    irq_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    localparam logic [1:0] RegData   = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegCtrl   = 2'd2;
    localparam logic [1:0] RegThresh = 2'd3;

    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [DataWidth-1:0] mem_q [Depth];

    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [CntW-1:0]      thresh_q, thresh_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 irq_en_q, irq_en_d;
    logic                 rvalid_q;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 irq_q, irq_d;

    logic                 push;
    logic                 empty;
    logic                 full;
    logic [1:0]           sel;
    logic [CntW-1:0]      thresh_wr;
    logic [DataWidth-1:0] status_word;
    logic                 unused_addr_bits;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DepthCnt);
    assign sel       = device_addr_i[3:2];
    assign thresh_wr = device_wdata_i[CntW-1:0];

    // Upper address bits alias onto the four registers.
    assign unused_addr_bits = ^{device_addr_i[AddressWidth-1:4], device_addr_i[1:0]};

    always_comb begin
        status_word       = '0;
        status_word[0]    = empty;
        status_word[1]    = full;
        status_word[2]    = ovf_q;
        status_word[3]    = udf_q;
        status_word[15:8] = 8'(count_q);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        thresh_d = thresh_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        irq_en_d = irq_en_q;
        rdata_d  = '0;
        err_d    = 1'b0;
        push     = 1'b0;

        if (device_req_i) begin
            if (device_we_i) begin
                case (sel)
                    RegData: begin
                        if (full) begin
                            err_d = 1'b1;
                            ovf_d = 1'b1;
                        end else if (device_be_i != 4'hF) begin
                            err_d = 1'b1;
                        end else begin
                            push     = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            count_d  = count_q + 1'b1;
                        end
                    end
                    RegCtrl: begin
                        if (device_be_i[0]) begin
                            irq_en_d = device_wdata_i[0];
                            if (device_wdata_i[1]) begin
                                wr_ptr_d = '0;
                                rd_ptr_d = '0;
                                count_d  = '0;
                                ovf_d    = 1'b0;
                                udf_d    = 1'b0;
                            end
                        end
                    end
                    RegThresh: begin
                        if (device_be_i[0]) begin
                            if (thresh_wr > DepthCnt) begin
                                thresh_d = DepthCnt;
                            end else if (thresh_wr == '0) begin
                                thresh_d = CntW'(1);
                            end else begin
                                thresh_d = thresh_wr;
                            end
                        end
                    end
                    default: ;
                endcase
            end else begin
                case (sel)
                    RegData: begin
                        if (empty) begin
                            err_d = 1'b1;
                            udf_d = 1'b1;
                        end else begin
                            rdata_d  = mem_q[rd_ptr_q];
                            rd_ptr_d = rd_ptr_q + 1'b1;
                            count_d  = count_q - 1'b1;
                        end
                    end
                    RegStatus: rdata_d = status_word;
                    RegCtrl:   rdata_d = DataWidth'(irq_en_q);
                    default:   rdata_d = DataWidth'(thresh_q);
                endcase
            end
        end

        // Evaluated on next-state values so irq_o is a plain flop aligned with count/thresh.
        irq_d = irq_en_d && (count_d >= thresh_d);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            thresh_q <= CntW'(1);
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            thresh_q <= thresh_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            irq_en_q <= irq_en_d;
            rvalid_q <= device_req_i;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            irq_q    <= irq_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= device_wdata_i;
        end
    end

    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;
    assign device_err_o    = err_q;
    assign irq_o           = irq_q;

endmodule

// File: tb/tb_bus_fifo_mailbox.sv
// Directed plus randomized bench for bus_fifo_mailbox against a queue-based mailbox model.
module tb_bus_fifo_mailbox;

    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        device_req_i = 1'b0;
    logic [31:0] device_addr_i = '0;
    logic        device_we_i = 1'b0;
    logic [3:0]  device_be_i = '0;
    logic [31:0] device_wdata_i = '0;
    logic        device_rvalid_o;
    logic [31:0] device_rdata_o;
    logic        device_err_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;
    bit          m_irq_en = 1'b0;
    int          m_thresh = 1;

    bus_fifo_mailbox #(
        .Depth(DEPTH),
        .DataWidth(32),
        .AddressWidth(32)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .device_req_i(device_req_i),
        .device_addr_i(device_addr_i),
        .device_we_i(device_we_i),
        .device_be_i(device_be_i),
        .device_wdata_i(device_wdata_i),
        .device_rvalid_o(device_rvalid_o),
        .device_rdata_o(device_rdata_o),
        .device_err_o(device_err_o),
        .irq_o(irq_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_irq_en = 1'b0;
        m_thresh = 1;
    endtask

    // Mailbox behaviour: a bounded queue plus sticky flags and an interrupt threshold.
    task automatic model(input bit we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata,
                         output logic [31:0] er, output logic ee, output logic ei);
        int v;
        er = '0;
        ee = 1'b0;
        if (we) begin
            case (addr[3:2])
                2'd0: begin
                    if (q.size() == DEPTH) begin
                        ee = 1'b1;
                        m_ovf = 1'b1;
                    end else if (be != 4'hF) begin
                        ee = 1'b1;
                    end else begin
                        q.push_back(wdata);
                    end
                end
                2'd2: begin
                    if (be[0]) begin
                        m_irq_en = wdata[0];
                        if (wdata[1]) begin
                            q.delete();
                            m_ovf = 1'b0;
                            m_udf = 1'b0;
                        end
                    end
                end
                2'd3: begin
                    if (be[0]) begin
                        v = int'(wdata[4:0]);
                        m_thresh = (v > DEPTH) ? DEPTH : ((v == 0) ? 1 : v);
                    end
                end
                default: ;
            endcase
        end else begin
            case (addr[3:2])
                2'd0: begin
                    if (q.size() == 0) begin
                        ee = 1'b1;
                        m_udf = 1'b1;
                    end else begin
                        er = q.pop_front();
                    end
                end
                2'd1: begin
                    er = 32'(q.size()) << 8;
                    er[0] = (q.size() == 0);
                    er[1] = (q.size() == DEPTH);
                    er[2] = m_ovf;
                    er[3] = m_udf;
                end
                2'd2: er = 32'(m_irq_en);
                default: er = 32'(m_thresh);
            endcase
        end
        ei = m_irq_en && (q.size() >= m_thresh);
    endtask

    // One request; response is checked #1 after the capturing edge, and the next
    // call may drive a new request immediately (back-to-back).
    task automatic xact(input bit we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input string tag);
        logic [31:0] er;
        logic        ee;
        logic        ei;
        model(we, addr, be, wdata, er, ee, ei);
        device_req_i   = 1'b1;
        device_we_i    = we;
        device_addr_i  = addr;
        device_be_i    = be;
        device_wdata_i = wdata;
        @(posedge CLK);
        #1;
        device_req_i = 1'b0;
        chk({tag, " rvalid"}, 32'(device_rvalid_o), 32'(1'b1));
        chk({tag, " rdata"}, device_rdata_o, er);
        chk({tag, " err"}, 32'(device_err_o), 32'(ee));
        chk({tag, " irq"}, 32'(irq_o), 32'(ei));
    endtask

    task automatic idle(input string tag);
        device_req_i = 1'b0;
        @(posedge CLK);
        #1;
        chk({tag, " idle rvalid"}, 32'(device_rvalid_o), 32'(1'b0));
        chk({tag, " idle irq"}, 32'(irq_o), 32'(m_irq_en && (q.size() >= m_thresh)));
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          we;
        int          r;

        #2 RST_N = 1'b0;
        #10;
        chk("reset rvalid", 32'(device_rvalid_o), 32'(1'b0));
        chk("reset err", 32'(device_err_o), 32'(1'b0));
        chk("reset rdata", device_rdata_o, 32'h0);
        chk("reset irq", 32'(irq_o), 32'(1'b0));
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST_N = 1'b1;
        model_reset();
        idle("post-reset");

        // Empty read error and clear.
        xact(1'b0, 32'h0, 4'hF, 32'h0, "empty rd");
        chk("empty rd err const", 32'(device_err_o), 32'(1'b1));
        xact(1'b0, 32'h4, 4'hF, 32'h0, "status udf");
        chk("status udf const", device_rdata_o, 32'h9);
        xact(1'b1, 32'h8, 4'hF, 32'h2, "ctrl clear");
        xact(1'b0, 32'h4, 4'hF, 32'h0, "status cleared");
        chk("status cleared const", device_rdata_o, 32'h1);

        // Push/pop ordering.
        xact(1'b1, 32'h0, 4'hF, 32'h11, "push11");
        xact(1'b1, 32'h0, 4'hF, 32'h22, "push22");
        xact(1'b1, 32'h0, 4'hF, 32'h33, "push33");
        idle("gap");
        xact(1'b0, 32'h0, 4'hF, 32'h0, "pop1");
        chk("pop1 const", device_rdata_o, 32'h11);
        xact(1'b0, 32'h0, 4'hF, 32'h0, "pop2");
        chk("pop2 const", device_rdata_o, 32'h22);
        xact(1'b0, 32'h0, 4'hF, 32'h0, "pop3");
        chk("pop3 const", device_rdata_o, 32'h33);
        xact(1'b0, 32'h4, 4'hF, 32'h0, "status drained");
        chk("status drained const", device_rdata_o, 32'h1);

        // Full, overflow and pointer wrap.
        for (int i = 0; i < DEPTH + 1; i++) begin
            xact(1'b1, 32'h0, 4'hF, 32'h100 + 32'(i), $sformatf("fill%0d", i));
        end
        chk("overflow push err const", 32'(device_err_o), 32'(1'b1));
        xact(1'b0, 32'h4, 4'hF, 32'h0, "status full");
        chk("status full const", device_rdata_o, 32'h1006);
        for (int i = 0; i < DEPTH; i++) begin
            xact(1'b0, 32'h0, 4'hF, 32'h0, $sformatf("drain%0d", i));
        end
        xact(1'b1, 32'h0, 4'hF, 32'hAA, "wrap push");
        xact(1'b0, 32'h0, 4'hF, 32'h0, "wrap pop");
        chk("wrap pop const", device_rdata_o, 32'hAA);
        xact(1'b1, 32'h8, 4'hF, 32'h2, "clear ovf");

        // Interrupt threshold.
        xact(1'b1, 32'hC, 4'hF, 32'h3, "thresh3");
        xact(1'b1, 32'h8, 4'hF, 32'h1, "irq en");
        xact(1'b1, 32'h0, 4'hF, 32'h1, "irq push1");
        xact(1'b1, 32'h0, 4'hF, 32'h2, "irq push2");
        chk("irq below const", 32'(irq_o), 32'(1'b0));
        xact(1'b1, 32'h0, 4'hF, 32'h3, "irq push3");
        chk("irq at thresh const", 32'(irq_o), 32'(1'b1));
        xact(1'b0, 32'h0, 4'hF, 32'h0, "irq pop");
        chk("irq dropped const", 32'(irq_o), 32'(1'b0));
        xact(1'b1, 32'hC, 4'hF, 32'h0, "thresh0");
        xact(1'b0, 32'hC, 4'hF, 32'h0, "thresh0 rd");
        chk("thresh0 rd const", device_rdata_o, 32'h1);
        xact(1'b1, 32'hC, 4'hF, 32'd20, "thresh20");
        xact(1'b0, 32'hC, 4'hF, 32'h0, "thresh sat rd");
        chk("thresh sat const", device_rdata_o, 32'd16);
        xact(1'b1, 32'hC, 4'hF, 32'h1, "thresh1");
        xact(1'b1, 32'h8, 4'hF, 32'h3, "clear+en");
        chk("clear+en irq const", 32'(irq_o), 32'(1'b0));
        xact(1'b0, 32'h8, 4'hF, 32'h0, "ctrl rd");
        chk("ctrl rd const", device_rdata_o, 32'h1);

        // Byte-enable check and aliasing.
        xact(1'b1, 32'h0, 4'hF, 32'h5, "be push");
        xact(1'b1, 32'h0, 4'h3, 32'h6, "be partial");
        chk("be partial err const", 32'(device_err_o), 32'(1'b1));
        xact(1'b0, 32'hFFFF_FFF4, 4'h1, 32'h0, "alias status");
        chk("be count unchanged const", device_rdata_o, 32'h0100);
        xact(1'b1, 32'h8, 4'hF, 32'h2, "clear2");

        // Randomized back-to-back traffic.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            addr = $urandom & 32'hFFFF_FFF0;
            addr[1:0] = 2'($urandom_range(0, 3));
            addr[3:2] = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            we = 1'($urandom_range(0, 1));
            be = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            wdata = $urandom;
            if (addr[3:2] == 2'd2) begin
                wdata[1] = ($urandom_range(0, 15) == 0);
            end else if (addr[3:2] == 2'd3) begin
                wdata = 32'($urandom_range(0, 20));
            end
            xact(we, addr, be, wdata, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 9) == 0) begin
                idle($sformatf("rnd%0d", i));
            end
        end

        // Reset in the cycle after a read request.
        xact(1'b1, 32'h8, 4'hF, 32'h3, "pre-rst clear");
        xact(1'b1, 32'hC, 4'hF, 32'h1, "pre-rst thresh");
        xact(1'b1, 32'h0, 4'hF, 32'h77, "pre-rst push");
        chk("pre-rst irq const", 32'(irq_o), 32'(1'b1));
        device_req_i   = 1'b1;
        device_we_i    = 1'b0;
        device_addr_i  = 32'h0;
        device_be_i    = 4'hF;
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        device_req_i = 1'b0;
        #1;
        chk("midrst rvalid", 32'(device_rvalid_o), 32'(1'b0));
        chk("midrst rdata", device_rdata_o, 32'h0);
        chk("midrst err", 32'(device_err_o), 32'(1'b0));
        chk("midrst irq", 32'(irq_o), 32'(1'b0));
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST_N = 1'b1;
        model_reset();
        idle("post-midrst");
        xact(1'b0, 32'h4, 4'hF, 32'h0, "midrst status");
        chk("midrst status const", device_rdata_o, 32'h1);
        xact(1'b0, 32'hC, 4'hF, 32'h0, "midrst thresh");
        chk("midrst thresh const", device_rdata_o, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
